// File: rtl/gate_checker.sv
// Self-checking stimulus/response unit: walks a 2-input gate under test through
// vectors 00,01,10,11 and compares each sampled result against TRUTH_TABLE.
module gate_checker #(
  parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       result,
  output logic       input_a,
  output logic       input_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vector,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] stim_q, stim_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       mismatch;

  // Handshake: start is a request level honoured only in IDLE/DONE; busy marks
  // the run in flight (start ignored), done is a level held until the next accept.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = (result != TRUTH_TABLE[idx_q]);

    case (state_q)
      IDLE, DONE: begin
        stim_d = 2'b00;
        if (start) begin
          state_d = SETTLE;
          idx_d   = 2'd0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          idx_d   = 2'd0;
          stim_d  = 2'b00;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // err_d already includes this final sample's contribution.
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 2'd1;
          stim_d  = idx_q + 2'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      stim_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign input_a     = stim_q[1];
  assign input_b     = stim_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_vector = fail_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: four instances with different truth tables and settle
// times, all driven by selectable gate models and checked against a vector-level model.
module tb_gate_checker;

  localparam int M_AND  = 0;
  localparam int M_OR   = 1;
  localparam int M_ONE  = 2;
  localparam int M_ZERO = 3;
  localparam int M_RAND = 4;
  localparam int M_DLY  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  int         mode = M_AND;
  logic [3:0] tbl = 4'd0;

  wire  [3:0] a_v, b_v, busy_v, done_v, pass_v, res_v;
  wire  [2:0] err_v [4];
  wire  [3:0] fv_v  [4];
  wire  [1:0] st_v  [4];
  logic [3:0] d1, d2;

  int total = 0;
  int bad   = 0;
  int k_done [4];

  always #5 clk = ~clk;

  function automatic logic [3:0] tt_of(input int k);
    case (k)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic int sc_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction

  // Gate models; M_DLY is an AND whose output lags its inputs by two clock cycles.
  function automatic logic gate_resp(input int m, input logic [3:0] t,
                                     input logic [1:0] ab, input logic dly);
    case (m)
      M_AND:   return (ab == 2'b11);
      M_OR:    return (ab != 2'b00);
      M_ONE:   return 1'b1;
      M_ZERO:  return 1'b0;
      M_RAND:  return t[ab];
      default: return dly;
    endcase
  endfunction

  // Vector i is applied on edge i*(SC+1) and sampled on edge (i+1)*(SC+1); a
  // gate with 2-cycle lag shows the vector that was in effect 3 edges earlier.
  function automatic logic [3:0] exp_fail(input int k, input int m, input logic [3:0] t);
    logic [3:0] f;
    logic [3:0] tt;
    int         sc, seen, tpos;
    logic       r;
    tt = tt_of(k);
    sc = sc_of(k);
    f  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      seen = i;
      if (m == M_DLY) begin
        tpos = (i + 1) * (sc + 1) - 3;
        seen = (tpos < 0) ? 0 : tpos / (sc + 1);
      end
      r = gate_resp(m, t, 2'(seen), (seen == 3));
      f[i] = (r != tt[i]);
    end
    return f;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_res
    assign res_v[g] = gate_resp(mode, tbl, {a_v[g], b_v[g]}, d2[g]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 4'd0;
      d2 <= 4'd0;
    end else begin
      d1 <= a_v & b_v;
      d2 <= d1;
    end
  end

  gate_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(4)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .result(res_v[0]),
    .input_a(a_v[0]), .input_b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .fail_vector(fv_v[0]), .state_dbg(st_v[0]));

  gate_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(4)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start), .result(res_v[1]),
    .input_a(a_v[1]), .input_b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .fail_vector(fv_v[1]), .state_dbg(st_v[1]));

  gate_checker #(.TRUTH_TABLE(4'b0111), .SETTLE_CYCLES(4)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start), .result(res_v[2]),
    .input_a(a_v[2]), .input_b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .fail_vector(fv_v[2]), .state_dbg(st_v[2]));

  gate_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start), .result(res_v[3]),
    .input_a(a_v[3]), .input_b(b_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .err_count(err_v[3]), .fail_vector(fv_v[3]), .state_dbg(st_v[3]));

  // Pulses start for one accept edge and records, per instance, the edge count
  // at which done first rises (-1 if it never does within the budget).
  task automatic run_wait(input int budget);
    int k;
    for (int j = 0; j < 4; j++) k_done[j] = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (k < budget && done_v != 4'b1111) begin
      @(negedge clk);
      k++;
      for (int j = 0; j < 4; j++)
        if (done_v[j] && k_done[j] < 0) k_done[j] = k;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      total++;
      if ({a_v[j], b_v[j], busy_v[j], done_v[j], pass_v[j], err_v[j], fv_v[j], st_v[j]} !== 14'd0) begin
        bad++;
        $display("FAIL reset inst%0d: got %b required 0", j,
                 {a_v[j], b_v[j], busy_v[j], done_v[j], pass_v[j], err_v[j], fv_v[j], st_v[j]});
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stimulus_order();
    logic [1:0] want;
    mode = M_AND;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if (busy_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept: got %b required 1", busy_v[0]);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      want = (k < 20) ? 2'(k / 5) : 2'b00;
      total++;
      if ({a_v[0], b_v[0], busy_v[0], done_v[0]} !== {want, (k < 20), (k == 20)}) begin
        bad++;
        $display("FAIL stim_order edge%0d: got ab=%b%b busy=%b done=%b required ab=%b busy=%b done=%b",
                 k, a_v[0], b_v[0], busy_v[0], done_v[0], want, (k < 20), (k == 20));
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_gate_models();
    int         modes [6];
    logic [3:0] ef;
    int         m;
    modes = '{M_AND, M_OR, M_ONE, M_ZERO, M_DLY, M_RAND};
    for (int it = 0; it < 11; it++) begin
      m    = (it < 6) ? modes[it] : M_RAND;
      mode = m;
      tbl  = 4'($urandom_range(0, 15));
      run_wait(100);
      for (int j = 0; j < 4; j++) begin
        ef = exp_fail(j, m, tbl);
        total++;
        if (k_done[j] != 4 * (sc_of(j) + 1)) begin
          bad++;
          $display("FAIL done_latency mode%0d inst%0d: got %0d required %0d", m, j, k_done[j], 4 * (sc_of(j) + 1));
        end
        total++;
        if (fv_v[j] !== ef) begin
          bad++;
          $display("FAIL fail_vector mode%0d tbl=%b inst%0d: got %b required %b", m, tbl, j, fv_v[j], ef);
        end
        total++;
        if (err_v[j] !== 3'($countones(ef))) begin
          bad++;
          $display("FAIL err_count mode%0d inst%0d: got %0d required %0d", m, j, err_v[j], $countones(ef));
        end
        total++;
        if ({pass_v[j], busy_v[j]} !== {(ef == 4'd0), 1'b0}) begin
          bad++;
          $display("FAIL pass mode%0d inst%0d: got pass=%b busy=%b required pass=%b busy=0", m, j, pass_v[j], busy_v[j], (ef == 4'd0));
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int kd;
    mode = M_AND;
    kd   = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 40 && kd < 0; k++) begin
      @(negedge clk);
      if (k == 6) start = 1'b1;
      if (k == 7) start = 1'b0;
      if (done_v[0]) kd = k;
    end
    total++;
    if (kd != 20 || pass_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL start_while_busy: got done_edge=%0d pass=%b required done_edge=20 pass=1", kd, pass_v[0]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_bad;
    mode = M_AND;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_v, b_v, busy_v, done_v, pass_v} !== 20'd0 || err_v[0] !== 3'd0 || fv_v[0] !== 4'd0 || st_v[0] !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid: got ab=%b%b busy=%b done=%b err=%0d fv=%b st=%0d required all 0",
               a_v[0], b_v[0], busy_v, done_v, err_v[0], fv_v[0], st_v[0]);
    end
    @(negedge clk) rst_n = 1'b1;
    seen_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_v !== 4'd0 || busy_v !== 4'd0 || a_v !== 4'd0 || b_v !== 4'd0) seen_bad++;
    end
    total++;
    if (seen_bad != 0) begin
      bad++;
      $display("FAIL idle_after_reset: got %0d active cycles required 0", seen_bad);
    end
  endtask

  task automatic test_restart_after_fail();
    mode = M_OR;
    run_wait(100);
    total++;
    if (err_v[0] !== 3'd2 || fv_v[0] !== 4'b0110 || done_v[0] !== 1'b1) begin
      bad++;
      $display("FAIL or_run: got err=%0d fv=%b done=%b required err=2 fv=0110 done=1", err_v[0], fv_v[0], done_v[0]);
    end
    mode = M_AND;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if ({err_v[0], fv_v[0], done_v[0], pass_v[0], busy_v[0]} !== 10'b000_0000_001) begin
      bad++;
      $display("FAIL restart_clear: got err=%0d fv=%b done=%b pass=%b busy=%b required 0 0000 0 0 1",
               err_v[0], fv_v[0], done_v[0], pass_v[0], busy_v[0]);
    end
    repeat (25) @(negedge clk);
    total++;
    if ({err_v[0], fv_v[0], done_v[0], pass_v[0]} !== 9'b000_0000_11) begin
      bad++;
      $display("FAIL restart_result: got err=%0d fv=%b done=%b pass=%b required 0 0000 1 1",
               err_v[0], fv_v[0], done_v[0], pass_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ef;
    mode = M_RAND;
    tbl  = 4'($urandom_range(0, 15));
    ef   = exp_fail(0, M_RAND, tbl);
    @(negedge clk) start = 1'b1;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k == 19 || k == 20 || k == 21 || k == 41) begin
        total++;
        if ({done_v[0], busy_v[0]} !== ((k == 20 || k == 41) ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL b2b_status edge%0d: got done=%b busy=%b", k, done_v[0], busy_v[0]);
        end
      end
      if (k == 20 || k == 41) begin
        total++;
        if (fv_v[0] !== ef || err_v[0] !== 3'($countones(ef))) begin
          bad++;
          $display("FAIL b2b_result edge%0d: got fv=%b err=%0d required fv=%b err=%0d",
                   k, fv_v[0], err_v[0], ef, $countones(ef));
        end
      end
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stimulus_order();
    test_gate_models();
    test_start_while_busy();
    test_reset_mid();
    test_restart_after_fail();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
